// File: rtl/time_monitor_rtc.sv
// Cycle-driven real-time timebase: prescaled seconds, epoch counter, broken-down
// time fields and N one-shot epoch alarms with sticky pending flags and irq.
module time_monitor_rtc #(
  parameter int unsigned CLKS_PER_SEC = 1,
  parameter int unsigned N_ALARM      = 2,
  parameter int unsigned EPOCH_W      = 64,
  parameter int unsigned DAY_W        = 16,
  localparam int unsigned IDX_W       = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load_valid,
  input  logic [EPOCH_W-1:0] load_epoch,
  input  logic [5:0]         load_sec,
  input  logic [5:0]         load_min,
  input  logic [4:0]         load_hour,
  input  logic [DAY_W-1:0]   load_day,
  output logic               load_err,
  input  logic               alarm_wr,
  input  logic [IDX_W-1:0]   alarm_idx,
  input  logic [EPOCH_W-1:0] alarm_epoch,
  input  logic [N_ALARM-1:0] alarm_clr,
  output logic               tick,
  output logic [EPOCH_W-1:0] epoch_sec,
  output logic [5:0]         tm_sec,
  output logic [5:0]         tm_min,
  output logic [4:0]         tm_hour,
  output logic [DAY_W-1:0]   tm_day,
  output logic [N_ALARM-1:0] alarm_armed,
  output logic [N_ALARM-1:0] alarm_pending,
  output logic               irq
);

  localparam int unsigned PS_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_SEC - 1);

  logic [PS_W-1:0]    ps_q, ps_d;
  logic [EPOCH_W-1:0] epoch_d;
  logic [5:0]         sec_d, min_d;
  logic [4:0]         hour_d;
  logic [DAY_W-1:0]   day_d;
  logic [EPOCH_W-1:0] cmp_q [N_ALARM];
  logic [EPOCH_W-1:0] cmp_d [N_ALARM];
  logic [N_ALARM-1:0] armed_d, pend_d;
  logic               fields_ok, load_ok, wrap, adv, idx_ok, wr_hit, fire;

  // Prescaler and time-field next state; a valid load overrides a second boundary.
  always_comb begin
    fields_ok = (load_sec < 6'd60) && (load_min < 6'd60) && (load_hour < 5'd24);
    load_ok   = load_valid && fields_ok;
    wrap      = en && (ps_q == PS_LAST);
    adv       = wrap && !load_ok;
    ps_d      = ps_q;
    epoch_d   = epoch_sec;
    sec_d     = tm_sec;
    min_d     = tm_min;
    hour_d    = tm_hour;
    day_d     = tm_day;
    if (load_ok) begin
      ps_d    = '0;
      epoch_d = load_epoch;
      sec_d   = load_sec;
      min_d   = load_min;
      hour_d  = load_hour;
      day_d   = load_day;
    end else if (en) begin
      ps_d = wrap ? '0 : ps_q + PS_W'(1);
      if (adv) begin
        epoch_d = epoch_sec + EPOCH_W'(1);
        if (tm_sec == 6'd59) begin
          sec_d = '0;
          if (tm_min == 6'd59) begin
            min_d = '0;
            if (tm_hour == 5'd23) begin
              hour_d = '0;
              day_d  = tm_day + DAY_W'(1);
            end else begin
              hour_d = tm_hour + 5'd1;
            end
          end else begin
            min_d = tm_min + 6'd1;
          end
        end else begin
          sec_d = tm_sec + 6'd1;
        end
      end
    end
  end

  // Alarm channels: write beats fire, fire beats clear.
  always_comb begin
    idx_ok  = 32'(alarm_idx) < N_ALARM;
    armed_d = alarm_armed;
    pend_d  = alarm_pending;
    wr_hit  = 1'b0;
    fire    = 1'b0;
    for (int i = 0; i < int'(N_ALARM); i++) begin
      cmp_d[i] = cmp_q[i];
      wr_hit   = alarm_wr && idx_ok && (alarm_idx == IDX_W'(i));
      fire     = adv && alarm_armed[i] && (epoch_d == cmp_q[i]);
      if (wr_hit) begin
        cmp_d[i]   = alarm_epoch;
        armed_d[i] = 1'b1;
      end else if (fire) begin
        armed_d[i] = 1'b0;
      end
      if (fire && !wr_hit) begin
        pend_d[i] = 1'b1;
      end else if (alarm_clr[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q          <= '0;
      tick          <= 1'b0;
      load_err      <= 1'b0;
      epoch_sec     <= '0;
      tm_sec        <= '0;
      tm_min        <= '0;
      tm_hour       <= '0;
      tm_day        <= '0;
      alarm_armed   <= '0;
      alarm_pending <= '0;
      irq           <= 1'b0;
      for (int i = 0; i < int'(N_ALARM); i++) cmp_q[i] <= '0;
    end else begin
      ps_q          <= ps_d;
      tick          <= adv;
      load_err      <= load_valid && !fields_ok;
      epoch_sec     <= epoch_d;
      tm_sec        <= sec_d;
      tm_min        <= min_d;
      tm_hour       <= hour_d;
      tm_day        <= day_d;
      alarm_armed   <= armed_d;
      alarm_pending <= pend_d;
      irq           <= |pend_d;
      for (int i = 0; i < int'(N_ALARM); i++) cmp_q[i] <= cmp_d[i];
    end
  end

endmodule

// File: tb/tb_time_monitor_rtc.sv
// Scoreboard bench for time_monitor_rtc with CLKS_PER_SEC=4 and two alarm channels.
module tb_time_monitor_rtc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic [63:0] load_epoch = '0;
  logic [5:0]  load_sec = '0;
  logic [5:0]  load_min = '0;
  logic [4:0]  load_hour = '0;
  logic [15:0] load_day = '0;
  logic        load_err;
  logic        alarm_wr = 1'b0;
  logic [0:0]  alarm_idx = '0;
  logic [63:0] alarm_epoch = '0;
  logic [1:0]  alarm_clr = '0;
  logic        tick;
  logic [63:0] epoch_sec;
  logic [5:0]  tm_sec, tm_min;
  logic [4:0]  tm_hour;
  logic [15:0] tm_day;
  logic [1:0]  alarm_armed, alarm_pending;
  logic        irq;

  time_monitor_rtc #(.CLKS_PER_SEC(4), .N_ALARM(2), .EPOCH_W(64), .DAY_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .load_valid(load_valid), .load_epoch(load_epoch), .load_sec(load_sec),
    .load_min(load_min), .load_hour(load_hour), .load_day(load_day), .load_err(load_err),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_epoch(alarm_epoch),
    .alarm_clr(alarm_clr), .tick(tick), .epoch_sec(epoch_sec), .tm_sec(tm_sec),
    .tm_min(tm_min), .tm_hour(tm_hour), .tm_day(tm_day),
    .alarm_armed(alarm_armed), .alarm_pending(alarm_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tick, err, irq;
    logic [63:0] epoch;
    logic [5:0]  sec, min;
    logic [4:0]  hour;
    logic [15:0] day;
    logic [1:0]  armed, pend;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int          m_ps;
  logic [63:0] m_epoch;
  logic [5:0]  m_sec, m_min;
  logic [4:0]  m_hour;
  logic [15:0] m_day;
  logic [1:0]  m_armed, m_pend;
  logic [63:0] m_cmp [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ps = 0; m_epoch = '0; m_sec = '0; m_min = '0; m_hour = '0; m_day = '0;
    m_armed = '0; m_pend = '0; m_cmp[0] = '0; m_cmp[1] = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tick"}, 64'(tick), 64'd0);
    check({tag, "_err"}, 64'(load_err), 64'd0);
    check({tag, "_epoch"}, epoch_sec, 64'd0);
    check({tag, "_fields"}, 64'({tm_sec, tm_min, tm_hour, tm_day}), 64'd0);
    check({tag, "_alarm"}, 64'({alarm_armed, alarm_pending, irq}), 64'd0);
  endtask

  // Predict the outcome of the coming edge, push it, then compare after the edge.
  task automatic step();
    exp_t e;
    logic rng, ld_ok, adv, wr, fire;
    rng   = (load_sec < 60) && (load_min < 60) && (load_hour < 24);
    ld_ok = load_valid && rng;
    adv   = en && (m_ps == 3) && !ld_ok;
    if (ld_ok) begin
      m_ps = 0; m_epoch = load_epoch; m_sec = load_sec; m_min = load_min;
      m_hour = load_hour; m_day = load_day;
    end else if (en) begin
      m_ps = (m_ps + 1) % 4;
      if (adv) begin
        m_epoch = m_epoch + 64'd1;
        m_sec = m_sec + 6'd1;
        if (m_sec == 60) begin m_sec = 0; m_min = m_min + 6'd1; end
        if (m_min == 60) begin m_min = 0; m_hour = m_hour + 5'd1; end
        if (m_hour == 24) begin m_hour = 0; m_day = m_day + 16'd1; end
      end
    end
    for (int i = 0; i < 2; i++) begin
      wr   = alarm_wr && (int'(alarm_idx) == i);
      fire = adv && m_armed[i] && (m_epoch == m_cmp[i]);
      if (wr) begin m_cmp[i] = alarm_epoch; m_armed[i] = 1'b1; end
      else if (fire) m_armed[i] = 1'b0;
      if (fire && !wr) m_pend[i] = 1'b1;
      else if (alarm_clr[i]) m_pend[i] = 1'b0;
    end
    e.tick = adv; e.err = load_valid && !rng; e.irq = |m_pend;
    e.epoch = m_epoch; e.sec = m_sec; e.min = m_min; e.hour = m_hour; e.day = m_day;
    e.armed = m_armed; e.pend = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("tick", 64'(tick), 64'(e.tick));
    check("load_err", 64'(load_err), 64'(e.err));
    check("epoch", epoch_sec, e.epoch);
    check("tm_sec", 64'(tm_sec), 64'(e.sec));
    check("tm_min", 64'(tm_min), 64'(e.min));
    check("tm_hour", 64'(tm_hour), 64'(e.hour));
    check("tm_day", 64'(tm_day), 64'(e.day));
    check("armed", 64'(alarm_armed), 64'(e.armed));
    check("pending", 64'(alarm_pending), 64'(e.pend));
    check("irq", 64'(irq), 64'(e.irq));
    load_valid = 1'b0; alarm_wr = 1'b0; alarm_clr = '0;
  endtask

  task automatic do_load(input logic [63:0] ep, input logic [5:0] s, input logic [5:0] mi,
                         input logic [4:0] h, input logic [15:0] d);
    load_valid = 1'b1; load_epoch = ep; load_sec = s; load_min = mi;
    load_hour = h; load_day = d;
  endtask

  initial begin
    int ticks, n;
    model_reset();
    #2;
    check_zero("reset");
    #10;
    rst_n = 1'b1;
    en = 1'b1;

    // Free run from reset: ticks on cycles 4, 8, 12
    ticks = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (tick) ticks++;
      if (c % 4 != 0) check("run_no_tick", 64'(tick), 64'd0);
    end
    check("run_ticks", 64'(ticks), 64'd3);
    check("run_epoch", epoch_sec, 64'd3);
    check("run_sec", 64'(tm_sec), 64'd3);

    // Full carry chain on one second
    do_load(64'd1000, 6'd59, 6'd59, 5'd23, 16'd5);
    step();
    for (int c = 0; c < 4; c++) step();
    check("carry_tick", 64'(tick), 64'd1);
    check("carry_epoch", epoch_sec, 64'd1001);
    check("carry_fields", 64'({tm_sec, tm_min, tm_hour}), 64'd0);
    check("carry_day", 64'(tm_day), 64'd6);

    // Out-of-range load is rejected
    do_load(64'd77, 6'd60, 6'd0, 5'd0, 16'd0);
    step();
    check("err_pulse", 64'(load_err), 64'd1);
    check("err_epoch_kept", epoch_sec, 64'd1001);
    step();
    check("err_one_cycle", 64'(load_err), 64'd0);

    // Alarm ch0 at 1003 fires on the third tick; coincident clear loses
    do_load(64'd1000, 6'd0, 6'd0, 5'd0, 16'd0);
    alarm_wr = 1'b1; alarm_idx = 1'b0; alarm_epoch = 64'd1003;
    step();
    for (int c = 0; c < 11; c++) step();
    check("alarm_not_yet", 64'(alarm_pending[0]), 64'd0);
    alarm_clr = 2'b01;
    step();
    check("alarm_fire_tick", 64'(tick), 64'd1);
    check("alarm_pending", 64'(alarm_pending[0]), 64'd1);
    check("alarm_irq", 64'(irq), 64'd1);
    check("alarm_disarmed", 64'(alarm_armed[0]), 64'd0);
    alarm_clr = 2'b01;
    step();
    check("alarm_cleared", 64'(alarm_pending[0]), 64'd0);
    check("irq_cleared", 64'(irq), 64'd0);

    // Load onto ch1's epoch at a prescaler wrap: no fire, no tick, prescaler restarts
    alarm_wr = 1'b1; alarm_idx = 1'b1; alarm_epoch = 64'd2000;
    step();
    n = 0;
    while (m_ps != 3 && n < 8) begin step(); n++; end
    check("wrap_align", 64'(m_ps), 64'd3);
    do_load(64'd2000, 6'd0, 6'd0, 5'd0, 16'd0);
    step();
    check("load_no_tick", 64'(tick), 64'd0);
    check("load_no_fire", 64'(alarm_pending), 64'd0);
    check("load_ch1_armed", 64'(alarm_armed[1]), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("restart_tick", 64'(tick), 64'(k == 4));
    end

    // Freeze mid-second then resume with remaining count
    step(); step();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("frozen_tick", 64'(tick), 64'd0);
    end
    en = 1'b1;
    n = 0;
    do begin step(); n++; end while (!tick && n < 4);
    check("resume_cycles", 64'(n), 64'd2);

    // Randomized traffic through the scoreboard
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0)
        do_load(m_epoch + 64'($urandom_range(0, 3)), 6'($urandom_range(0, 62)),
                6'($urandom_range(0, 59)), 5'($urandom_range(0, 24)), 16'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        alarm_wr = 1'b1; alarm_idx = 1'($urandom_range(0, 1));
        alarm_epoch = m_epoch + 64'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 4) == 0) alarm_clr = 2'($urandom_range(0, 3));
      step();
    end

    // Asynchronous reset mid-count
    step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_reset");
    #2 rst_n = 1'b1;
    step();
    check("post_reset_epoch", epoch_sec, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
